floor_scroller: RTL and testbench
=================================

# floor_scroller

Parametrised successor to the fixed eight-floor generator. It keeps N_FLOORS platforms in live registers and scrolls them all down while the player presses against the ceiling, at a speed tier set by `time_gap`. A floor that leaves the bottom of the screen is recycled to the top with a fresh x position. Outputs are frame-synchronised snapshots for the VGA renderer, so a frame never shows a half-applied scroll.

## Interface
- N_FLOORS, 8, number of floors (2..16)
- COORD_W, 10, coordinate width; must hold SCREEN_H-1 and X_MAX
- SCREEN_H, 480, visible rows; y wraps at SCREEN_H-1 -> 0
- SPACING, 60, reset y spacing: y_i = i*SPACING; requires (N_FLOORS-1)*SPACING < SCREEN_H
- X_BASE, 150 and X_STRIDE, 150: reset x_i = X_BASE + (i mod 4)*X_STRIDE
- X_MIN, 100 and X_MAX, 550: recycle x range; require 256 <= X_MAX-X_MIN+1 <= 512
- LFSR_SEED, 16'hACE1, nonzero
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- step  in  1  one-cycle scroll strobe (floor tick)
- frame_tick  in  1  one-cycle frame-boundary strobe
- hit_ceiling  in  1  scroll request
- time_gap  in  9  speed-tier selector
- floor_x  out  N_FLOORS*COORD_W  snapshot x, floor i at [i*COORD_W +: COORD_W]
- floor_y  out  N_FLOORS*COORD_W  snapshot y, same packing
- enable  out  N_FLOORS  snapshot floor-visible flags
- recycle_pulse  out  1  one-cycle pulse when any floor wrapped this step
- scroll_px  out  16  total pixels scrolled, saturates at 16'hFFFF

## Operation
- Speed tier from `time_gap`:
  - 1..79: T1, scroll on every step.
  - 80..159: T2, scroll when phase[0]==0.
  - 160..239: T3, scroll when phase[1:0]==0.
  - 240..319: T4, scroll when phase[2:0]==0.
  - 0 or >=320: T0, never scroll.
- Phase counter (3 bits):
  - Increments, with wrap, on each step while hit_ceiling=1.
  - Cleared on any cycle with hit_ceiling=0.
  - The scroll decision uses the pre-increment phase.
- Scroll event: step & hit_ceiling & tier condition true.
  - Every live y_i += 1.
  - scroll_px += 1, saturating.
- Wrap: a floor with y_i == SCREEN_H-1 goes to 0 on a scroll event instead.
  - Its x_i is reloaded (see Configuration).
  - recycle_pulse=1 for that cycle; several floors wrapping at once still give a single pulse.
- Snapshot on frame_tick: floor_x/floor_y/enable are loaded from the live registers.
- Live enable bits are always 1; recycling never disables a floor.

## Timing
- Async reset, applied whenever rst=0, including mid-scroll:
  - Live and snapshot y_i = i*SPACING, x_i = X_BASE+(i mod 4)*X_STRIDE.
  - enable = all ones, phase = 0, scroll_px = 0, recycle_pulse = 0, LFSR = LFSR_SEED.
- Scroll latency: live registers update on the clock edge that samples step; recycle_pulse is registered in the same edge.
- Snapshot latency: outputs change on the edge sampling frame_tick.
- Simultaneous step and frame_tick: the snapshot takes the pre-step live values, and the step is still applied to the live registers. The new positions appear at the next frame_tick.
- step is ignored while hit_ceiling=0 or tier is T0; live state holds.
- The LFSR advances on every clock, regardless of step.

## Configuration
- FLOOR_RANDOM_X_EN defined:
  - A recycled floor takes x = X_MIN + r', where r = LFSR[8:0].
  - r' = r - (X_MAX-X_MIN+1) if r >= that range, else r'= r.
  - Result is always within [X_MIN, X_MAX].
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
- Undefined:
  - Recycled floors keep their reset column x.
  - No LFSR is instantiated.

## Structure
- Package floor_pkg holds:
  - Tier thresholds 80/160/240/320 as localparams.
  - The tier enum T0..T4.
  - The LFSR tap mask.
  - The reset-layout functions init_y(i) and init_x(i).
- Sub-module floor_lfsr holds the 16-bit LFSR with seed parameter, compiled only under FLOOR_RANDOM_X_EN.
- Live floors are a generate loop over N_FLOORS.

## Test plan
- Reset, then release: floor_y = 0,60,...,420; floor_x = 150,300,450,600,150,...; enable=8'hFF; scroll_px=0.
- time_gap=10, hit_ceiling=1, 3 steps, frame_tick -> every floor_y +3, scroll_px=3.
- time_gap=100, 4 steps -> live y +2 (scrolls on steps 1 and 3). time_gap=250, 8 steps -> +1. time_gap=0 or 320, 5 steps -> no change.
- Default layout, T1, 60 steps:
  - On step 60, floor 7 goes 479 -> 0 and recycle_pulse fires once.
  - With the macro, x7 is within [100,550].
  - Without it, x7=600.
- step and frame_tick in the same cycle -> snapshot shows old y; next frame_tick shows y+1.
- Drop rst to 0 mid-run with phase=2 and scroll_px=37 -> all outputs return to reset values immediately. After release, T2 scrolls on the first step (phase=0).

Source files
------------

// File: rtl/floor_pkg.sv
// Shared definitions for floor_scroller: speed-tier thresholds, tier enum and reset layout.
// The LFSR tap mask exists only when FLOOR_RANDOM_X_EN is defined.
package floor_pkg;

    localparam logic [8:0] TIER2_MIN    = 9'd80;
    localparam logic [8:0] TIER3_MIN    = 9'd160;
    localparam logic [8:0] TIER4_MIN    = 9'd240;
    localparam logic [8:0] TIER_OFF_MIN = 9'd320;

`ifdef FLOOR_RANDOM_X_EN
    // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
`endif

    typedef enum logic [2:0] {T0, T1, T2, T3, T4} tier_t;

    function automatic tier_t tier_of(input logic [8:0] gap);
        if (gap == 9'd0 || gap >= TIER_OFF_MIN) return T0;
        if (gap < TIER2_MIN)                    return T1;
        if (gap < TIER3_MIN)                    return T2;
        if (gap < TIER4_MIN)                    return T3;
        return T4;
    endfunction

    function automatic int unsigned init_y(input int unsigned idx, input int unsigned spacing);
        return idx * spacing;
    endfunction

    function automatic int unsigned init_x(input int unsigned idx, input int unsigned base,
                                           input int unsigned stride);
        return base + (idx % 4) * stride;
    endfunction

endpackage

// File: rtl/floor_lfsr.sv
// 16-bit Fibonacci LFSR supplying recycle x offsets; built only with FLOOR_RANDOM_X_EN.
`ifdef FLOOR_RANDOM_X_EN
module floor_lfsr
    import floor_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [8:0] rand_bits
);

    logic [15:0] state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SEED;
        else      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end

    assign rand_bits = state[8:0];

endmodule
`endif

// File: rtl/floor_scroller.sv
// Scrolls N_FLOORS live platforms on ceiling pressure and publishes frame-synchronised snapshots.
// FLOOR_RANDOM_X_EN: recycled floors take an LFSR-derived x instead of their reset column.
module floor_scroller
    import floor_pkg::*;
#(
    parameter int unsigned N_FLOORS  = 8,
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned SPACING   = 60,
    parameter int unsigned X_BASE    = 150,
    parameter int unsigned X_STRIDE  = 150,
    parameter int unsigned X_MIN     = 100,
    parameter int unsigned X_MAX     = 550,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          step,
    input  logic                          frame_tick,
    input  logic                          hit_ceiling,
    input  logic [8:0]                    time_gap,
    output logic [N_FLOORS*COORD_W-1:0]   floor_x,
    output logic [N_FLOORS*COORD_W-1:0]   floor_y,
    output logic [N_FLOORS-1:0]           enable,
    output logic                          recycle_pulse,
    output logic [15:0]                   scroll_px
);

    localparam logic [COORD_W-1:0] Y_TOP = COORD_W'(SCREEN_H - 1);

    if (N_FLOORS < 2 || N_FLOORS > 16 || (N_FLOORS - 1) * SPACING >= SCREEN_H ||
        X_MAX < X_MIN || X_MAX - X_MIN + 1 < 256 || X_MAX - X_MIN + 1 > 512 ||
        LFSR_SEED == 16'h0) begin : g_bad_cfg
        $error("floor_scroller: invalid parameter set");
    end

    tier_t               tier;
    logic                tier_hit;
    logic                scroll;
    logic [2:0]          phase;
    logic [N_FLOORS-1:0] at_top;

    always_comb begin
        tier     = tier_of(time_gap);
        tier_hit = 1'b0;
        case (tier)
            T1:      tier_hit = 1'b1;
            T2:      tier_hit = (phase[0] == 1'b0);
            T3:      tier_hit = (phase[1:0] == 2'b00);
            T4:      tier_hit = (phase == 3'b000);
            default: tier_hit = 1'b0;
        endcase
        scroll = step & hit_ceiling & tier_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase         <= '0;
            scroll_px     <= '0;
            recycle_pulse <= 1'b0;
        end else begin
            if (!hit_ceiling) phase <= '0;
            else if (step)    phase <= phase + 3'd1;
            if (scroll && scroll_px != '1) scroll_px <= scroll_px + 16'd1;
            recycle_pulse <= scroll & (|at_top);
        end
    end

`ifdef FLOOR_RANDOM_X_EN
    localparam logic [9:0] X_SPAN = 10'(X_MAX - X_MIN + 1);

    logic [8:0]         rand_bits;
    logic [9:0]         r_ext;
    logic [9:0]         r_adj;
    logic [COORD_W-1:0] x_recycle;

    floor_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .rand_bits (rand_bits)
    );

    // A single conditional subtract suffices because the span is at least 256 and r < 512.
    always_comb begin
        r_ext     = {1'b0, rand_bits};
        r_adj     = (r_ext >= X_SPAN) ? r_ext - X_SPAN : r_ext;
        x_recycle = COORD_W'(X_MIN) + COORD_W'(r_adj);
    end
`endif

    for (genvar i = 0; i < N_FLOORS; i++) begin : g_floor
        localparam logic [COORD_W-1:0] Y0 = COORD_W'(init_y(i, SPACING));
        localparam logic [COORD_W-1:0] X0 = COORD_W'(init_x(i, X_BASE, X_STRIDE));

        logic [COORD_W-1:0] y_live, x_live, y_snap, x_snap;

        assign at_top[i] = (y_live == Y_TOP);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                y_live <= Y0;
                x_live <= X0;
                y_snap <= Y0;
                x_snap <= X0;
            end else begin
                if (frame_tick) begin
                    y_snap <= y_live;
                    x_snap <= x_live;
                end
                if (scroll) begin
                    if (at_top[i]) begin
                        y_live <= '0;
`ifdef FLOOR_RANDOM_X_EN
                        x_live <= x_recycle;
`endif
                    end else begin
                        y_live <= y_live + 1'b1;
                    end
                end
            end
        end

        assign floor_y[i*COORD_W +: COORD_W] = y_snap;
        assign floor_x[i*COORD_W +: COORD_W] = x_snap;
    end

    // Live floors are never disabled, so the snapshot of their enable bits is constant.
    assign enable = '1;

endmodule

// File: tb/tb_floor_scroller.sv
// Self-checking bench for floor_scroller: tier table, hand-written corner sequences, random run.
module tb_floor_scroller;

    localparam int N = 8;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           step, frame_tick, hit_ceiling;
    logic [8:0]     time_gap;
    logic [N*W-1:0] floor_x, floor_y;
    logic [N-1:0]   enable;
    logic           recycle_pulse;
    logic [15:0]    scroll_px;

    floor_scroller #(.N_FLOORS(N), .COORD_W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .step          (step),
        .frame_tick    (frame_tick),
        .hit_ceiling   (hit_ceiling),
        .time_gap      (time_gap),
        .floor_x       (floor_x),
        .floor_y       (floor_y),
        .enable        (enable),
        .recycle_pulse (recycle_pulse),
        .scroll_px     (scroll_px)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: positions as plain integers, scroll period derived from time_gap ranges.
    int my[N], mx[N], sy[N], sx[N];
    bit lrec[N], srec[N];
    int mphase, mpx;
    bit mpulse;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            my[i] = i * 60;
            mx[i] = 150 + (i % 4) * 150;
            sy[i] = my[i];
            sx[i] = mx[i];
            lrec[i] = 0;
            srec[i] = 0;
        end
        mphase = 0;
        mpx    = 0;
        mpulse = 0;
    endfunction

    function automatic void model_clock(input bit s, input bit ft, input bit hc, input int tg);
        int  per;
        bit  do_scroll;
        if (tg >= 1 && tg < 80)         per = 1;
        else if (tg >= 80 && tg < 160)  per = 2;
        else if (tg >= 160 && tg < 240) per = 4;
        else if (tg >= 240 && tg < 320) per = 8;
        else                            per = 0;
        if (ft) begin
            for (int i = 0; i < N; i++) begin
                sy[i] = my[i];
                sx[i] = mx[i];
                srec[i] = lrec[i];
            end
        end
        do_scroll = s && hc && per != 0 && (mphase % per == 0);
        if (!hc)    mphase = 0;
        else if (s) mphase = (mphase + 1) % 8;
        mpulse = 0;
        if (do_scroll) begin
            for (int i = 0; i < N; i++) begin
                if (my[i] == 479) begin
                    my[i]   = 0;
                    lrec[i] = 1;
                    mpulse  = 1;
                end else begin
                    my[i] = my[i] + 1;
                end
            end
            if (mpx < 65535) mpx = mpx + 1;
        end
    endfunction

    task automatic check_all(input string tag);
        logic [W-1:0] xv;
        check($sformatf("%s pulse", tag), 32'(recycle_pulse), 32'(mpulse));
        check($sformatf("%s scroll_px", tag), 32'(scroll_px), 32'(mpx));
        check($sformatf("%s enable", tag), 32'(enable), 32'hFF);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s y[%0d]", tag, i), 32'(floor_y[i*W +: W]), 32'(sy[i]));
            xv = floor_x[i*W +: W];
`ifdef FLOOR_RANDOM_X_EN
            if (srec[i])
                check($sformatf("%s x[%0d] in range", tag, i),
                      32'(xv >= 10'd100 && xv <= 10'd550), 32'd1);
            else
                check($sformatf("%s x[%0d]", tag, i), 32'(xv), 32'(sx[i]));
`else
            check($sformatf("%s x[%0d]", tag, i), 32'(xv), 32'(sx[i]));
`endif
        end
    endtask

    task automatic cycle(input bit s, input bit ft, input bit hc, input logic [8:0] tg,
                         input string tag);
        step = s; frame_tick = ft; hit_ceiling = hc; time_gap = tg;
        @(posedge clk);
        model_clock(s, ft, hc, int'(tg));
        #1;
        step = 1'b0; frame_tick = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; step = 1'b0; frame_tick = 1'b0; hit_ceiling = 1'b0; time_gap = '0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_clock(0, 0, 0, 0);
        #1;
        check_all("post_reset");
    endtask

    typedef struct {
        logic [8:0] gap;
        int         steps;
        int         dy;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int base_y, base_px, npulse, pulse_step;
        logic [W-1:0] x7;

        vecs[0]  = '{9'd10,  3, 3};
        vecs[1]  = '{9'd100, 4, 2};
        vecs[2]  = '{9'd250, 8, 1};
        vecs[3]  = '{9'd0,   5, 0};
        vecs[4]  = '{9'd320, 5, 0};
        vecs[5]  = '{9'd200, 8, 2};
        vecs[6]  = '{9'd79,  2, 2};
        vecs[7]  = '{9'd80,  2, 1};
        vecs[8]  = '{9'd159, 4, 2};
        vecs[9]  = '{9'd160, 4, 1};
        vecs[10] = '{9'd239, 8, 2};
        vecs[11] = '{9'd240, 8, 1};
        vecs[12] = '{9'd319, 9, 2};
        vecs[13] = '{9'd511, 3, 0};
        vecs[14] = '{9'd1,   1, 1};

        rst = 1'b0; step = 1'b0; frame_tick = 1'b0; hit_ceiling = 1'b0; time_gap = '0;
        do_reset();
        check("reset y7", 32'(floor_y[7*W +: W]), 32'd420);
        check("reset x3", 32'(floor_x[3*W +: W]), 32'd600);
        check("reset x4", 32'(floor_x[4*W +: W]), 32'd150);

        // Tier table: clear phase, apply steps, snapshot, compare against table deltas.
        for (int v = 0; v < 15; v++) begin
            cycle(0, 0, 0, vecs[v].gap, "tbl_clear");
            base_y  = my[0];
            base_px = mpx;
            for (int k = 0; k < vecs[v].steps; k++)
                cycle(1, 0, 1, vecs[v].gap, "tbl_step");
            cycle(0, 1, 1, vecs[v].gap, "tbl_snap");
            check($sformatf("tier gap=%0d dy", vecs[v].gap),
                  32'(floor_y[0 +: W]), 32'(base_y + vecs[v].dy));
            check($sformatf("tier gap=%0d px", vecs[v].gap),
                  32'(scroll_px), 32'(base_px + vecs[v].dy));
        end

        // Floor 7 wraps on exactly the 60th scroll from the reset layout.
        do_reset();
        npulse = 0;
        pulse_step = 0;
        for (int k = 1; k <= 60; k++) begin
            cycle(1, 0, 1, 9'd10, "wrap_step");
            if (recycle_pulse === 1'b1) begin
                npulse++;
                pulse_step = k;
            end
        end
        check("wrap pulse count", 32'(npulse), 32'd1);
        check("wrap pulse step", 32'(pulse_step), 32'd60);
        cycle(0, 0, 1, 9'd10, "wrap_idle");
        check("wrap pulse drops", 32'(recycle_pulse), 32'd0);
        cycle(0, 1, 1, 9'd10, "wrap_snap");
        check("wrap y7", 32'(floor_y[7*W +: W]), 32'd0);
        check("wrap y0", 32'(floor_y[0 +: W]), 32'd60);
        x7 = floor_x[7*W +: W];
`ifdef FLOOR_RANDOM_X_EN
        check("wrap x7 in range", 32'(x7 >= 10'd100 && x7 <= 10'd550), 32'd1);
`else
        check("wrap x7", 32'(x7), 32'd600);
`endif

        // Step and frame_tick together: snapshot holds pre-step y, next tick shows the step.
        base_y = my[1];
        cycle(1, 1, 1, 9'd10, "sim_both");
        check("simul old y1", 32'(floor_y[1*W +: W]), 32'(base_y));
        cycle(0, 1, 1, 9'd10, "sim_next");
        check("simul new y1", 32'(floor_y[1*W +: W]), 32'(base_y + 1));

        // Asynchronous reset mid-run with phase=2 and scroll_px=37.
        do_reset();
        for (int k = 0; k < 37; k++) cycle(1, 0, 1, 9'd10, "mid_step");
        cycle(0, 0, 0, 9'd0, "mid_clear");
        cycle(1, 0, 1, 9'd0, "mid_t0");
        cycle(1, 0, 1, 9'd0, "mid_t0");
        cycle(0, 1, 1, 9'd0, "mid_snap");
        check("mid px", 32'(scroll_px), 32'd37);
        check("mid y0", 32'(floor_y[0 +: W]), 32'd37);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        check("async y0", 32'(floor_y[0 +: W]), 32'd0);
        check("async px", 32'(scroll_px), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cycle(1, 0, 1, 9'd100, "rel_t2");
        cycle(0, 1, 1, 9'd100, "rel_snap");
        check("release T2 first step", 32'(floor_y[0 +: W]), 32'd1);

        // Randomised run against the model.
        do_reset();
        time_gap = 9'd10;
        for (int k = 0; k < 2000; k++) begin
            logic [8:0] g;
            g = time_gap;
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 7))
                    0: g = 9'd0;
                    1: g = 9'd79;
                    2: g = 9'd80;
                    3: g = 9'd239;
                    4: g = 9'd320;
                    5: g = 9'd319;
                    default: g = 9'($urandom_range(1, 90));
                endcase
            end
            cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
                  bit'($urandom_range(0, 9) != 0), g, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
